// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and widths for the SPI slave
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = $clog2(DEF_DATA_W);

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop pin synchroniser with change detect
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_edge
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Shift the pin through the chain; the extra flop holds last cycle's synced level
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_edge = r_chain[STAGES-1] ^ r_prev;

endmodule

// File: rtl/spi_slave_modes.sv
// rtl/spi_slave_modes.sv - SPI slave, modes 0-3; SPI_SLAVE_ERR_FLAGS_EN adds sticky overrun/underrun flags
module spi_slave_modes
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              P_CLK,
  input  logic              reset,
  input  logic              i_CPOL,
  input  logic              i_CPHA,
  input  logic [DATA_W-1:0] i_TX_DATA,
  input  logic              i_TX_DV,
  output logic              o_TX_READY,
  output logic [DATA_W-1:0] o_RX_DATA,
  output logic              o_RX_DV,
  output logic              o_BUSY,
  input  logic              S_CLK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_OE
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  ,
  input  logic              i_ERR_CLR,
  input  logic              i_RX_ACK,
  output logic              o_RX_OVERRUN,
  output logic              o_TX_UNDERRUN
`endif
);

  localparam int L_CNT_W   = (DATA_W == DEF_DATA_W) ? CNT_W : $clog2(DATA_W);
  localparam int L_FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [L_CNT_W-1:0]   L_LAST  = L_CNT_W'(DATA_W - 1);
  localparam logic [L_FLUSH_W-1:0] L_FLUSH = L_FLUSH_W'(SYNC_STAGES);

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  logic w_sclk_sync, w_sclk_edge, w_ss_sync, w_ss_edge, w_mosi;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  spi_state_t  r_state, w_state_nxt;
  spi_mode_t   r_mode;
  logic [L_CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]    r_rx_shift, r_tx_shift, r_hold, r_rx_data;
  logic                 r_hold_full, r_miso, r_done, r_rx_dv, r_armed;
  logic [L_FLUSH_W-1:0] r_flush;

  logic w_start, w_sample, w_drive, w_last, w_load, w_tx_take, w_lead, w_trail;
  logic [DATA_W-1:0] w_load_word, w_rx_next;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(P_CLK), .i_reset(reset), .i_async(S_CLK), .o_sync(w_sclk_sync), .o_edge(w_sclk_edge)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(P_CLK), .i_reset(reset), .i_async(i_SS), .o_sync(w_ss_sync), .o_edge(w_ss_edge)
  );

  // MOSI only needs the same latency as S_CLK, no edge detect
  always_ff @(posedge P_CLK) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_MOSI};
  end

  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead      = w_sclk_edge & (w_sclk_sync != r_mode.cpol);
  assign w_trail     = w_sclk_edge & (w_sclk_sync == r_mode.cpol);
  assign w_last      = w_sample & (r_bit_cnt == L_LAST);
  assign w_load      = w_start | w_last;
  assign w_load_word = r_hold_full ? r_hold : '0;
  assign w_tx_take   = i_TX_DV & ~r_hold_full;
  assign w_rx_next   = (MSB_FIRST != 0) ? {r_rx_shift[DATA_W-2:0], w_mosi}
                                        : {w_mosi, r_rx_shift[DATA_W-1:1]};

  // FSM state register
  always_ff @(posedge P_CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus per-cycle frame start / sample / drive strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_edge && !w_ss_sync && r_armed) begin
          w_start     = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_ss_edge && w_ss_sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_sample = r_mode.cpha ? w_trail : w_lead;
          w_drive  = r_mode.cpha ? w_lead  : w_trail;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // After reset, wait until the SS chain reflects the pin and shows it high before a fall can start a frame
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != L_FLUSH) r_flush <= r_flush + 1'b1;
      if (r_flush == L_FLUSH && w_ss_sync) r_armed <= 1'b1;
    end
  end

  // Mode latch, bit counter and RX/TX shift registers
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      r_mode     <= '0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_mode    <= '{cpol: i_CPOL, cpha: i_CPHA};
        r_bit_cnt <= '0;
        if (!i_CPHA) begin
          // CPHA=0: master samples on the first edge, so bit 0 must already be out
          r_miso     <= head_bit(w_load_word);
          r_tx_shift <= shift_out(w_load_word);
        end else begin
          r_miso     <= 1'b0;
          r_tx_shift <= w_load_word;
        end
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
        // Next word goes in unshifted; the following drive edge presents its first bit
        if (w_last) begin
          r_tx_shift <= w_load_word;
        end else if (w_drive) begin
          r_miso     <= head_bit(r_tx_shift);
          r_tx_shift <= shift_out(r_tx_shift);
        end
      end
    end
  end

  // Publish completed word one cycle after the final sample
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      r_rx_data <= '0;
      r_rx_dv   <= 1'b0;
    end else begin
      r_rx_dv <= r_done;
      if (r_done) r_rx_data <= r_rx_shift;
    end
  end

  // TX holding register: write only when empty, emptied by each word load
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_tx_take) begin
      r_hold      <= i_TX_DATA;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  assign o_TX_READY = ~r_hold_full;
  assign o_RX_DATA  = r_rx_data;
  assign o_RX_DV    = r_rx_dv;
  assign o_BUSY     = (r_state == ACTIVE);
  assign o_MISO_OE  = o_BUSY;
  assign o_MISO     = o_MISO_OE ? r_miso : 1'bz;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic r_rx_pend, r_ovr, r_udr;

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      r_rx_pend <= 1'b0;
      r_ovr     <= 1'b0;
      r_udr     <= 1'b0;
    end else begin
      if (r_rx_dv)       r_rx_pend <= 1'b1;
      else if (i_RX_ACK) r_rx_pend <= 1'b0;
      if (r_done && r_rx_pend && !i_RX_ACK) r_ovr <= 1'b1;
      else if (i_ERR_CLR)                   r_ovr <= 1'b0;
      if (w_load && !r_hold_full) r_udr <= 1'b1;
      else if (i_ERR_CLR)         r_udr <= 1'b0;
    end
  end

  assign o_RX_OVERRUN  = r_ovr;
  assign o_TX_UNDERRUN = r_udr;
`endif

endmodule

// File: tb/tb_spi_slave_modes.sv
// tb/tb_spi_slave_modes.sv - directed bench for spi_slave_modes (LSB-first and MSB-first instances)
module tb_spi_slave_modes;

  localparam int HALF = 80;

  logic P_CLK = 1'b0;
  logic reset, i_CPOL, i_CPHA, S_CLK, i_SS, i_MOSI;
  logic [7:0] tx_l_data, tx_m_data;
  logic tx_l_dv, tx_m_dv;
  logic tx_l_rdy, tx_m_rdy, rx_l_dv, rx_m_dv, busy_l, busy_m, oe_l, oe_m;
  logic [7:0] rx_l_data, rx_m_data;
  wire miso_l, miso_m;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic err_clr, rx_ack;
  logic ovr_l, udr_l, ovr_m, udr_m;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt_l = 0;
  int dv_cnt_m = 0;
  logic [7:0] cap_l [0:15];
  time t_dv_l, t_sample;
  logic cur_cpol, cur_cpha;

  spi_slave_modes #(.DATA_W(8), .MSB_FIRST(0), .SYNC_STAGES(2)) dut_lsb (
    .P_CLK(P_CLK), .reset(reset), .i_CPOL(i_CPOL), .i_CPHA(i_CPHA),
    .i_TX_DATA(tx_l_data), .i_TX_DV(tx_l_dv), .o_TX_READY(tx_l_rdy),
    .o_RX_DATA(rx_l_data), .o_RX_DV(rx_l_dv), .o_BUSY(busy_l),
    .S_CLK(S_CLK), .i_SS(i_SS), .i_MOSI(i_MOSI), .o_MISO(miso_l), .o_MISO_OE(oe_l)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    , .i_ERR_CLR(err_clr), .i_RX_ACK(rx_ack), .o_RX_OVERRUN(ovr_l), .o_TX_UNDERRUN(udr_l)
`endif
  );

  spi_slave_modes #(.DATA_W(8), .MSB_FIRST(1), .SYNC_STAGES(2)) dut_msb (
    .P_CLK(P_CLK), .reset(reset), .i_CPOL(i_CPOL), .i_CPHA(i_CPHA),
    .i_TX_DATA(tx_m_data), .i_TX_DV(tx_m_dv), .o_TX_READY(tx_m_rdy),
    .o_RX_DATA(rx_m_data), .o_RX_DV(rx_m_dv), .o_BUSY(busy_m),
    .S_CLK(S_CLK), .i_SS(i_SS), .i_MOSI(i_MOSI), .o_MISO(miso_m), .o_MISO_OE(oe_m)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    , .i_ERR_CLR(err_clr), .i_RX_ACK(rx_ack), .o_RX_OVERRUN(ovr_m), .o_TX_UNDERRUN(udr_m)
`endif
  );

  always #5 P_CLK = ~P_CLK;

  always @(negedge P_CLK) begin
    if (rx_l_dv === 1'b1) begin
      if (dv_cnt_l < 16) cap_l[dv_cnt_l] = rx_l_data;
      dv_cnt_l = dv_cnt_l + 1;
      t_dv_l = $time;
    end
    if (rx_m_dv === 1'b1) dv_cnt_m = dv_cnt_m + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_write(input logic to_msb, input logic [7:0] d);
    @(negedge P_CLK);
    if (to_msb) begin tx_m_data = d; tx_m_dv = 1'b1; end
    else        begin tx_l_data = d; tx_l_dv = 1'b1; end
    @(negedge P_CLK);
    tx_m_dv = 1'b0;
    tx_l_dv = 1'b0;
  endtask

  task automatic spi_begin(input logic cpol, input logic cpha);
    @(negedge P_CLK);
    cur_cpol = cpol; cur_cpha = cpha;
    i_CPOL = cpol;   i_CPHA = cpha;
    S_CLK = cpol;
    #100;
    i_SS = 1'b0;
    #200;
  endtask

  task automatic spi_bits(input logic msb, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rl, output logic [7:0] rm);
    rl = 8'h00;
    rm = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = msb ? 7 - i : i;
      if (!cur_cpha) begin
        i_MOSI = tx[idx];
        #HALF;
        rl[i] = miso_l; rm[7-i] = miso_m;
        S_CLK = ~cur_cpol; t_sample = $time;
        #HALF;
        S_CLK = cur_cpol;
      end else begin
        S_CLK = ~cur_cpol;
        i_MOSI = tx[idx];
        #HALF;
        rl[i] = miso_l; rm[7-i] = miso_m;
        S_CLK = cur_cpol; t_sample = $time;
        #HALF;
      end
    end
  endtask

  task automatic spi_end();
    #HALF;
    i_SS = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] rl, rm;
    int base;
    reset = 1'b1; i_SS = 1'b1; S_CLK = 1'b0; i_MOSI = 1'b0;
    i_CPOL = 1'b0; i_CPHA = 1'b0; cur_cpol = 1'b0; cur_cpha = 1'b0;
    tx_l_data = 8'h00; tx_m_data = 8'h00; tx_l_dv = 1'b0; tx_m_dv = 1'b0;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    err_clr = 1'b0; rx_ack = 1'b0;
`endif
    repeat (3) @(negedge P_CLK);
    reset = 1'b0;
    @(negedge P_CLK);
    check_eq("rst_tx_ready", tx_l_rdy, 1);
    check_eq("rst_rx_data", rx_l_data, 8'h00);
    check_eq("rst_rx_dv", rx_l_dv, 0);
    check_eq("rst_busy", busy_l, 0);
    check_eq("rst_miso_oe", oe_l, 0);
    check_eq("rst_msb_tx_ready", tx_m_rdy, 1);
    repeat (5) @(negedge P_CLK);

    // Mode 0, LSB first: A5 out, 3C in
    tx_write(1'b0, 8'hA5);
    check_eq("tx_ready_after_write", tx_l_rdy, 0);
    base = dv_cnt_l;
    spi_begin(1'b0, 1'b0);
    check_eq("busy_in_frame", busy_l, 1);
    check_eq("oe_in_frame", oe_l, 1);
    spi_bits(1'b0, 8'h3C, 8, rl, rm);
    spi_end();
    check_eq("m0_miso_word", rl, 8'hA5);
    check_eq("m0_rx_data", rx_l_data, 8'h3C);
    check_eq("m0_dv_count", dv_cnt_l - base, 1);
    check_eq("m0_dv_latency", 32'((t_dv_l - t_sample) / 10), 4);
    check_eq("m0_busy_after", busy_l, 0);

    // Modes 1..3, MSB first: C3 out, 5A in
    for (int m = 1; m < 4; m++) begin
      logic [1:0] mm;
      mm = 2'(m);
      tx_write(1'b1, 8'hC3);
      base = dv_cnt_m;
      spi_begin(mm[1], mm[0]);
      spi_bits(1'b1, 8'h5A, 8, rl, rm);
      spi_end();
      check_eq($sformatf("mode%0d_miso_word", m), rm, 8'hC3);
      check_eq($sformatf("mode%0d_rx_data", m), rx_m_data, 8'h5A);
      check_eq($sformatf("mode%0d_dv_count", m), dv_cnt_m - base, 1);
    end

    // Three back-to-back words in one frame, third word underruns
    tx_write(1'b0, 8'h11);
    base = dv_cnt_l;
    spi_begin(1'b0, 1'b0);
    check_eq("b2b_ready_after_load", tx_l_rdy, 1);
    tx_write(1'b0, 8'h22);
    check_eq("b2b_ready_after_write", tx_l_rdy, 0);
    spi_bits(1'b0, 8'h01, 8, rl, rm);
    check_eq("b2b_miso_w0", rl, 8'h11);
    spi_bits(1'b0, 8'h02, 8, rl, rm);
    check_eq("b2b_miso_w1", rl, 8'h22);
    spi_bits(1'b0, 8'h03, 8, rl, rm);
    check_eq("b2b_miso_w2", rl, 8'h00);
    spi_end();
    check_eq("b2b_dv_count", dv_cnt_l - base, 3);
    check_eq("b2b_rx_w0", cap_l[base], 8'h01);
    check_eq("b2b_rx_w1", cap_l[base+1], 8'h02);
    check_eq("b2b_rx_w2", cap_l[base+2], 8'h03);

    // Frame aborted after 5 bits
    base = dv_cnt_l;
    spi_begin(1'b0, 1'b0);
    spi_bits(1'b0, 8'hFF, 5, rl, rm);
    i_SS = 1'b1;
    repeat (4) @(negedge P_CLK);
    check_eq("abort_oe_off", oe_l, 0);
    #200;
    check_eq("abort_no_dv", dv_cnt_l - base, 0);
    check_eq("abort_rx_held", rx_l_data, 8'h03);
    tx_write(1'b0, 8'h96);
    spi_begin(1'b0, 1'b0);
    spi_bits(1'b0, 8'h69, 8, rl, rm);
    spi_end();
    check_eq("post_abort_miso", rl, 8'h96);
    check_eq("post_abort_rx", rx_l_data, 8'h69);

    // Reset pulsed mid-word
    tx_write(1'b0, 8'h5C);
    spi_begin(1'b0, 1'b0);
    spi_bits(1'b0, 8'hAA, 4, rl, rm);
    @(negedge P_CLK);
    reset = 1'b1;
    @(negedge P_CLK);
    reset = 1'b0;
    check_eq("midrst_tx_ready", tx_l_rdy, 1);
    check_eq("midrst_rx_data", rx_l_data, 8'h00);
    check_eq("midrst_rx_dv", rx_l_dv, 0);
    check_eq("midrst_busy", busy_l, 0);
    check_eq("midrst_oe", oe_l, 0);
    check_eq("midrst_msb_busy", busy_m, 0);
    i_SS = 1'b1;
    #300;
    tx_write(1'b0, 8'hE7);
    spi_begin(1'b0, 1'b0);
    spi_bits(1'b0, 8'h7E, 8, rl, rm);
    spi_end();
    check_eq("post_rst_miso", rl, 8'hE7);
    check_eq("post_rst_rx", rx_l_data, 8'h7E);

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    @(negedge P_CLK); err_clr = 1'b1;
    @(negedge P_CLK); err_clr = 1'b0;
    check_eq("err_clr_ovr", ovr_l, 0);
    check_eq("err_clr_udr", udr_l, 0);
    spi_begin(1'b0, 1'b0);
    spi_bits(1'b0, 8'h12, 8, rl, rm);
    spi_bits(1'b0, 8'h34, 8, rl, rm);
    spi_end();
    check_eq("err_ovr_set", ovr_l, 1);
    check_eq("err_udr_set", udr_l, 1);
    @(negedge P_CLK); err_clr = 1'b1;
    @(negedge P_CLK); err_clr = 1'b0;
    check_eq("err_ovr_cleared", ovr_l, 0);
    check_eq("err_udr_cleared", udr_l, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
